// File: rtl/divider_unit.sv
// rtl/divider_unit.sv - multi-cycle restoring shift-subtract integer divider (DIV/DIVU)
//
// Ports:
//   i_clk          rising-edge clock
//   i_reset        synchronous active-high reset
//   i_start        start request, sampled only while idle
//   i_signed       1 = signed (DIV), 0 = unsigned (DIVU), captured with i_start
//   i_dividend     dividend A, captured with i_start
//   i_divisor      divisor B, captured with i_start
//   o_busy         high from the cycle after acceptance until o_done
//   o_done         one-cycle pulse, results valid in that cycle
//   o_quotient     quotient, held until the next completion
//   o_remainder    remainder, held until the next completion
//   o_div_by_zero  divisor was zero, held with the results
module divider_unit #(
    parameter int NB_DATA  = 32,
    parameter int NB_COUNT = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_signed,
    input  logic [NB_DATA-1:0] i_dividend,
    input  logic [NB_DATA-1:0] i_divisor,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_quotient,
    output logic [NB_DATA-1:0] o_remainder,
    output logic               o_div_by_zero
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [NB_COUNT-1:0] count;
    logic [NB_DATA-1:0]  rem;
    // Holds |A| while iterating; on a zero divisor it holds the untouched dividend instead.
    logic [NB_DATA-1:0]  quo;
    logic [NB_DATA-1:0]  dvs;
    logic                q_neg;
    logic                r_neg;
    logic                dz;

    logic               a_neg;
    logic               b_neg;
    logic               div_zero_in;
    logic [NB_DATA-1:0] a_mag;
    logic [NB_DATA-1:0] b_mag;

    logic [NB_DATA:0]   shifted;
    logic               trial_ok;
    logic [NB_DATA-1:0] rem_next;
    logic [NB_DATA-1:0] quo_next;
    logic [NB_DATA-1:0] q_res;
    logic [NB_DATA-1:0] r_res;

    assign a_neg       = i_signed & i_dividend[NB_DATA-1];
    assign b_neg       = i_signed & i_divisor[NB_DATA-1];
    assign div_zero_in = (i_divisor == '0);
    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    assign a_mag       = a_neg ? (~i_dividend + 1'b1) : i_dividend;
    assign b_mag       = b_neg ? (~i_divisor + 1'b1) : i_divisor;

    // The shifted partial remainder needs one extra bit: rem < |B| can reach 2^NB_DATA-2.
    assign shifted  = {rem, quo[NB_DATA-1]};
    assign trial_ok = (shifted >= {1'b0, dvs});
    // When the trial succeeds the difference is below |B|, so modular low bits are exact.
    assign rem_next = trial_ok ? (shifted[NB_DATA-1:0] - dvs) : shifted[NB_DATA-1:0];
    assign quo_next = {quo[NB_DATA-2:0], trial_ok};

    assign q_res = dz ? '1  : (q_neg ? (~quo + 1'b1) : quo);
    assign r_res = dz ? quo : (r_neg ? (~rem + 1'b1) : rem);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = div_zero_in ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (count == NB_COUNT'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count         <= '0;
            rem           <= '0;
            quo           <= '0;
            dvs           <= '0;
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            dz            <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        o_busy <= 1'b1;
                        count  <= NB_COUNT'(NB_DATA);
                        rem    <= '0;
                        dvs    <= b_mag;
                        dz     <= div_zero_in;
                        q_neg  <= a_neg ^ b_neg;
                        r_neg  <= a_neg;
                        quo    <= div_zero_in ? i_dividend : a_mag;
                    end
                end
                ST_RUN: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count - NB_COUNT'(1);
                end
                ST_DONE: begin
                    o_busy        <= 1'b0;
                    o_done        <= 1'b1;
                    o_quotient    <= q_res;
                    o_remainder   <= r_res;
                    o_div_by_zero <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
// tb/tb_divider_unit.sv - scoreboard testbench for divider_unit
module tb_divider_unit;

    localparam int NB = 32;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_start;
    logic          i_signed;
    logic [NB-1:0] i_dividend;
    logic [NB-1:0] i_divisor;
    logic          o_busy;
    logic          o_done;
    logic [NB-1:0] o_quotient;
    logic [NB-1:0] o_remainder;
    logic          o_div_by_zero;

    divider_unit #(.NB_DATA(NB), .NB_COUNT(6)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_signed     (i_signed),
        .i_dividend   (i_dividend),
        .i_divisor    (i_divisor),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_quotient   (o_quotient),
        .o_remainder  (o_remainder),
        .o_div_by_zero(o_div_by_zero)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [NB-1:0] q;
        logic [NB-1:0] r;
        logic          dz;
        int            done_cyc;
        int            id;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   op_id    = 0;
    logic rst_edge = 1'b1;

    logic [NB-1:0] last_q;
    logic [NB-1:0] last_r;
    logic          last_dz;

    always @(posedge i_clk) begin
        cyc++;
        rst_edge = i_reset;
    end

    // Reference: plain integer arithmetic; SV longint division truncates toward zero.
    function automatic exp_t model(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic s);
        exp_t   e;
        longint sa;
        longint sd;
        e.done_cyc = 0;
        e.id       = 0;
        if (b == 0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else if (s) begin
            sa   = longint'($signed(a));
            sd   = longint'($signed(b));
            e.q  = NB'(sa / sd);
            e.r  = NB'(sa % sd);
            e.dz = 1'b0;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [NB-1:0] got, input logic [NB-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Called at a negedge; waits for idle (with spurious ignored starts), then issues one op.
    task automatic issue(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic s, input bit noise);
        exp_t e;
        int   guard;
        guard = 0;
        while (o_busy && guard < 100) begin
            i_start    = noise && ($urandom_range(0, 3) == 0);
            i_dividend = $urandom;
            i_divisor  = $urandom;
            i_signed   = 1'($urandom);
            @(negedge i_clk);
            guard++;
        end
        i_start = 1'b0;
        if (o_busy) begin
            check("issue_wait_idle", {31'b0, o_busy}, 32'd0);
            return;
        end
        e          = model(a, b, s);
        e.done_cyc = cyc + 1 + ((b == 0) ? 1 : NB + 1);
        e.id       = op_id++;
        exp_q.push_back(e);
        i_start    = 1'b1;
        i_dividend = a;
        i_divisor  = b;
        i_signed   = s;
        @(negedge i_clk);
        i_start    = 1'b0;
        i_dividend = $urandom;
        i_divisor  = $urandom;
        i_signed   = 1'($urandom);
    endtask

    function automatic logic [NB-1:0] pick_val(input bit is_div);
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return is_div ? 32'h0 : 32'h1;
            3: return NB'($urandom_range(0, 20));
            4: return is_div ? NB'($urandom_range(1, 9)) : 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops the scoreboard on o_done, checks latency, and that outputs hold between completions.
    always @(negedge i_clk) begin
        exp_t e;
        if (rst_edge) begin
            last_q  = o_quotient;
            last_r  = o_remainder;
            last_dz = o_div_by_zero;
        end else begin
            if (o_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done got=1 want=0 at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("quotient#%0d", e.id), o_quotient, e.q);
                    check($sformatf("remainder#%0d", e.id), o_remainder, e.r);
                    check($sformatf("div_by_zero#%0d", e.id), {31'b0, o_div_by_zero}, {31'b0, e.dz});
                    check($sformatf("done_cycle#%0d", e.id), cyc, e.done_cyc);
                    check($sformatf("busy_at_done#%0d", e.id), {31'b0, o_busy}, 32'd0);
                end
            end else begin
                if (o_quotient !== last_q || o_remainder !== last_r || o_div_by_zero !== last_dz) begin
                    checks++;
                    failures++;
                    $display("FAIL output_hold got=%h/%h/%b want=%h/%h/%b", o_quotient, o_remainder,
                             o_div_by_zero, last_q, last_r, last_dz);
                end
                if (exp_q.size() != 0 && cyc > exp_q[0].done_cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL done_timeout#%0d got=none want=cycle %0d", e.id, e.done_cyc);
                end
            end
            last_q  = o_quotient;
            last_r  = o_remainder;
            last_dz = o_div_by_zero;
        end
    end

    initial begin
        int guard;
        i_reset    = 1'b1;
        i_start    = 1'b0;
        i_signed   = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        repeat (3) @(negedge i_clk);
        check("reset_busy", {31'b0, o_busy}, 32'd0);
        check("reset_done", {31'b0, o_done}, 32'd0);
        check("reset_quotient", o_quotient, 32'd0);
        check("reset_remainder", o_remainder, 32'd0);
        check("reset_dz", {31'b0, o_div_by_zero}, 32'd0);
        i_reset = 1'b0;
        @(negedge i_clk);

        // Directed cases, issued back to back.
        issue(32'd100, 32'd7, 1'b0, 1'b0);
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        issue(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        issue(32'd5, 32'd0, 1'b0, 1'b0);
        issue(32'd5, 32'd0, 1'b1, 1'b0);
        issue(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0);

        // Reset mid-run: 50/5 at E0, ignored 9/3 at E10, reset over E20/E21.
        guard = 0;
        while ((o_busy || exp_q.size() != 0) && guard < 100) begin
            @(negedge i_clk);
            guard++;
        end
        issue(32'd50, 32'd5, 1'b0, 1'b0);
        repeat (9) @(negedge i_clk);
        i_start    = 1'b1;
        i_dividend = 32'd9;
        i_divisor  = 32'd3;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (9) @(negedge i_clk);
        i_reset = 1'b1;
        exp_q.delete();
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        check("abort_busy", {31'b0, o_busy}, 32'd0);
        check("abort_quotient", o_quotient, 32'd0);
        check("abort_remainder", o_remainder, 32'd0);
        repeat (3) @(negedge i_clk);
        issue(32'd9, 32'd3, 1'b0, 1'b0);

        // Randomized operations with spurious starts while busy.
        for (int n = 0; n < 40; n++) begin
            logic [NB-1:0] a;
            logic [NB-1:0] b;
            a = pick_val(1'b0);
            b = pick_val(1'b1);
            issue(a, b, 1'($urandom), 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 4)) @(negedge i_clk);
            end
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge i_clk);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        repeat (3) @(negedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
